// File: rtl/inst_encoder_loader_pkg.sv
// Shared opcode/func constants, encoder op selects and FSM state type for the instruction loader.
package inst_encoder_loader_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;

    localparam logic [5:0] FUNC_ADD  = 6'h20;
    localparam logic [5:0] FUNC_ADDU = 6'h21;
    localparam logic [5:0] FUNC_SUB  = 6'h22;
    localparam logic [5:0] FUNC_SUBU = 6'h23;
    localparam logic [5:0] FUNC_AND  = 6'h24;
    localparam logic [5:0] FUNC_OR   = 6'h25;
    localparam logic [5:0] FUNC_XOR  = 6'h26;
    localparam logic [5:0] FUNC_SLT  = 6'h2A;
    localparam logic [5:0] FUNC_SLL  = 6'h00;
    localparam logic [5:0] FUNC_SRL  = 6'h02;

    localparam logic [4:0] ENC_OP_ADD   = 5'd0;
    localparam logic [4:0] ENC_OP_ADDU  = 5'd1;
    localparam logic [4:0] ENC_OP_SUB   = 5'd2;
    localparam logic [4:0] ENC_OP_SUBU  = 5'd3;
    localparam logic [4:0] ENC_OP_AND   = 5'd4;
    localparam logic [4:0] ENC_OP_OR    = 5'd5;
    localparam logic [4:0] ENC_OP_XOR   = 5'd6;
    localparam logic [4:0] ENC_OP_SLT   = 5'd7;
    localparam logic [4:0] ENC_OP_SLL   = 5'd8;
    localparam logic [4:0] ENC_OP_SRL   = 5'd9;
    localparam logic [4:0] ENC_OP_ADDI  = 5'd10;
    localparam logic [4:0] ENC_OP_ADDIU = 5'd11;
    localparam logic [4:0] ENC_OP_ORI   = 5'd12;
    localparam logic [4:0] ENC_OP_LUI   = 5'd13;
    localparam logic [4:0] ENC_OP_LW    = 5'd14;
    localparam logic [4:0] ENC_OP_SW    = 5'd15;
    localparam logic [4:0] ENC_OP_BEQ   = 5'd16;
    localparam logic [4:0] ENC_OP_J     = 5'd17;
    localparam logic [4:0] ENC_OP_JAL   = 5'd18;
    localparam int unsigned ENC_OP_LENGTH = 19;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} load_state_e;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sa;
        logic [15:0] imm;
        logic [25:0] target;
    } enc_fields_t;

    function automatic logic [31:0] r_word(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                           logic [4:0] sa, logic [5:0] func);
        return {OPC_RTYPE, rs, rt, rd, sa, func};
    endfunction

    function automatic logic [31:0] i_word(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                           logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/inst_word_pack.sv
// Combinational packer: encoder op select plus operand fields -> 32-bit MIPS word and legal flag.
module inst_word_pack
    import inst_encoder_loader_pkg::*;
(
    input  logic [4:0]  op_i,
    input  enc_fields_t fields_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = 32'h0;
        legal_o = 1'b1;
        case (op_i)
            ENC_OP_ADD:   word_o = r_word(fields_i.rs, fields_i.rt, fields_i.rd, 5'd0, FUNC_ADD);
            ENC_OP_ADDU:  word_o = r_word(fields_i.rs, fields_i.rt, fields_i.rd, 5'd0, FUNC_ADDU);
            ENC_OP_SUB:   word_o = r_word(fields_i.rs, fields_i.rt, fields_i.rd, 5'd0, FUNC_SUB);
            ENC_OP_SUBU:  word_o = r_word(fields_i.rs, fields_i.rt, fields_i.rd, 5'd0, FUNC_SUBU);
            ENC_OP_AND:   word_o = r_word(fields_i.rs, fields_i.rt, fields_i.rd, 5'd0, FUNC_AND);
            ENC_OP_OR:    word_o = r_word(fields_i.rs, fields_i.rt, fields_i.rd, 5'd0, FUNC_OR);
            ENC_OP_XOR:   word_o = r_word(fields_i.rs, fields_i.rt, fields_i.rd, 5'd0, FUNC_XOR);
            ENC_OP_SLT:   word_o = r_word(fields_i.rs, fields_i.rt, fields_i.rd, 5'd0, FUNC_SLT);
            // Shifts take their source from rt; rs is not part of the instruction.
            ENC_OP_SLL:   word_o = r_word(5'd0, fields_i.rt, fields_i.rd, fields_i.sa, FUNC_SLL);
            ENC_OP_SRL:   word_o = r_word(5'd0, fields_i.rt, fields_i.rd, fields_i.sa, FUNC_SRL);
            ENC_OP_ADDI:  word_o = i_word(OPC_ADDI, fields_i.rs, fields_i.rt, fields_i.imm);
            ENC_OP_ADDIU: word_o = i_word(OPC_ADDIU, fields_i.rs, fields_i.rt, fields_i.imm);
            ENC_OP_ORI:   word_o = i_word(OPC_ORI, fields_i.rs, fields_i.rt, fields_i.imm);
            ENC_OP_LUI:   word_o = i_word(OPC_LUI, 5'd0, fields_i.rt, fields_i.imm);
            ENC_OP_LW:    word_o = i_word(OPC_LW, fields_i.rs, fields_i.rt, fields_i.imm);
            ENC_OP_SW:    word_o = i_word(OPC_SW, fields_i.rs, fields_i.rt, fields_i.imm);
            ENC_OP_BEQ:   word_o = i_word(OPC_BEQ, fields_i.rs, fields_i.rt, fields_i.imm);
            ENC_OP_J:     word_o = {OPC_J, fields_i.target};
            ENC_OP_JAL:   word_o = {OPC_JAL, fields_i.target};
            default: begin
                word_o  = 32'h0;
                legal_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Loads encoded instruction beats sequentially into imem and holds the CPU until done.
// ENC_ILLEGAL_CHECK_EN: drop illegal op beats and raise sticky err instead of writing a NOP.
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic              load_done_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [4:0]        in_op_i,
    input  logic [4:0]        in_rs_i,
    input  logic [4:0]        in_rt_i,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_sa_i,
    input  logic [15:0]       in_imm_i,
    input  logic [25:0]       in_target_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              full_o,
    output logic              busy_o,
    output logic              cpu_hold_o,
    output logic              err_o
);

    localparam int unsigned CntW = ADDR_W + 1;

    load_state_e       state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CntW-1:0]   count_q, count_d;

    enc_fields_t fields;
    logic [31:0] pack_word;
    logic        pack_legal;
    logic [CntW-1:0] fill;
    logic        accept, write_beat, start;

    assign fields = '{rs: in_rs_i, rt: in_rt_i, rd: in_rd_i, sa: in_sa_i,
                      imm: in_imm_i, target: in_target_i};

    inst_word_pack u_pack (
        .op_i    (in_op_i),
        .fields_i(fields),
        .word_o  (pack_word),
        .legal_o (pack_legal)
    );

    // Words committed plus the one in flight; ready drops once this reaches DEPTH.
    assign fill       = count_q + CntW'(we_q);
    assign in_ready_o = (state_q == StLoad) && (fill != CntW'(DEPTH));
    assign accept     = in_valid_i && in_ready_o;
    assign start      = load_start_i && ((state_q == StIdle) || (state_q == StDone));
`ifdef ENC_ILLEGAL_CHECK_EN
    assign write_beat = accept && pack_legal;
`else
    assign write_beat = accept;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = write_beat;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q + CntW'(we_q);
        if (write_beat) begin
            addr_d  = fill[ADDR_W-1:0];
            wdata_d = pack_legal ? pack_word : 32'h0;  // illegal selects become NOP
        end
        case (state_q)
            StIdle:  if (load_start_i) state_d = StLoad;
            StLoad:  if (load_done_i) state_d = StDrain;
            StDrain: if (!we_q) state_d = StDone;
            StDone:  if (load_start_i) state_d = StLoad;
            default: state_d = StIdle;
        endcase
        if (start) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
        end
    end

`ifdef ENC_ILLEGAL_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept && !pack_legal) begin
            err_d = 1'b1;
        end
        if (start) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign imem_we_o    = we_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign word_count_o = count_q;
    assign full_o       = (count_q == CntW'(DEPTH));
    assign busy_o       = (state_q == StLoad) || (state_q == StDrain);
    assign cpu_hold_o   = (state_q != StDone);

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Randomized plus directed bench for inst_encoder_loader against a session-level reference model.
module tb_inst_encoder_loader;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_start, load_done, in_valid, in_ready;
    logic [4:0]        in_op, in_rs, in_rt, in_rd, in_sa;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              full, busy, cpu_hold, err;

    inst_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_start_i(load_start),
        .load_done_i (load_done),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_op_i     (in_op),
        .in_rs_i     (in_rs),
        .in_rt_i     (in_rt),
        .in_rd_i     (in_rd),
        .in_sa_i     (in_sa),
        .in_imm_i    (in_imm),
        .in_target_i (in_target),
        .imem_we_o   (imem_we),
        .imem_addr_o (imem_addr),
        .imem_wdata_o(imem_wdata),
        .word_count_o(word_count),
        .full_o      (full),
        .busy_o      (busy),
        .cpu_hold_o  (cpu_hold),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model: phase 0 idle, 1 loading, 2 draining, 3 done.
    int unsigned m_phase, m_cnt, m_acc, m_pend_addr;
    bit          m_pend, m_err;
    logic [31:0] m_pend_data;

    logic [31:0] obs_data[$];
    int unsigned obs_addr[$];

    logic [5:0] func_tab [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A,
                                  6'h00, 6'h02};
    logic [5:0] opc_tab  [9]  = '{6'h08, 6'h09, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_encode(input int unsigned op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [4:0] rd,
                                               input logic [4:0] sa, input logic [15:0] imm,
                                               input logic [25:0] tgt);
        if (op < 8) return {6'h00, rs, rt, rd, 5'd0, func_tab[op]};
        if (op < 10) return {6'h00, 5'd0, rt, rd, sa, func_tab[op]};
        if (op == 13) return {opc_tab[op-10], 5'd0, rt, imm};
        if (op < 17) return {opc_tab[op-10], rs, rt, imm};
        if (op < 19) return {opc_tab[op-10], tgt};
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_cnt = 0; m_acc = 0; m_pend = 0; m_err = 0;
        m_pend_addr = 0; m_pend_data = 32'h0;
    endtask

    task automatic check_cycle();
        check_eq("in_ready", in_ready, (m_phase == 1) && (m_acc < DEPTH));
        check_eq("imem_we", imem_we, m_pend);
        if (m_pend) begin
            check_eq("imem_addr", imem_addr, m_pend_addr);
            check_eq("imem_wdata", imem_wdata, m_pend_data);
        end
        if (imem_we === 1'b1) begin
            obs_data.push_back(imem_wdata);
            obs_addr.push_back(imem_addr);
        end
        check_eq("word_count", word_count, m_cnt);
        check_eq("full", full, m_cnt == DEPTH);
        check_eq("busy", busy, (m_phase == 1) || (m_phase == 2));
        check_eq("cpu_hold", cpu_hold, m_phase != 3);
        check_eq("err", err, m_err);
    endtask

    task automatic model_update();
        bit acc, wr, legal;
        int unsigned n_cnt;
        acc   = in_valid && (m_phase == 1) && (m_acc < DEPTH);
        legal = in_op < 19;
`ifdef ENC_ILLEGAL_CHECK_EN
        wr = acc && legal;
        if (acc && !legal) m_err = 1;
`else
        wr = acc;
`endif
        n_cnt = m_cnt + m_pend;
        if (wr) begin
            m_pend_addr = m_acc;
            m_pend_data = ref_encode(in_op, in_rs, in_rt, in_rd, in_sa, in_imm, in_target);
            m_acc++;
        end
        if (load_start && (m_phase == 0 || m_phase == 3)) begin
            m_phase = 1; n_cnt = 0; m_acc = 0; m_err = 0;
        end else if (m_phase == 1 && load_done) begin
            m_phase = 2;
        end else if (m_phase == 2 && !m_pend) begin
            m_phase = 3;
        end
        m_cnt  = n_cnt;
        m_pend = wr;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                        input logic [25:0] tgt, input bit done);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa; in_imm = imm;
        in_target = tgt; in_valid = 1'b1; load_done = done;
        step();
        in_valid = 1'b0; load_done = 1'b0;
    endtask

    task automatic start_session();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        obs_data.delete();
        obs_addr.delete();
    endtask

    task automatic finish_session();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        idle_steps(3);
    endtask

    initial begin
        rst = 1'b1; load_start = 0; load_done = 0; in_valid = 0;
        in_op = 0; in_rs = 0; in_rt = 0; in_rd = 0; in_sa = 0; in_imm = 0; in_target = 0;
        model_reset();
        #2;
        check_eq("rst_addr", imem_addr, 0);
        check_eq("rst_wdata", imem_wdata, 0);
        do_reset();
        idle_steps(2);

        // Single ADD, then done: one write and hold release.
        start_session();
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1);
        idle_steps(3);
        check_eq("t1_nwrites", obs_data.size(), 1);
        if (obs_data.size() >= 1) begin
            check_eq("t1_data", obs_data[0], 32'h0022_1820);
            check_eq("t1_addr", obs_addr[0], 0);
        end
        check_eq("t1_hold", cpu_hold, 1'b0);

        // Back-to-back ADDI, BEQ, J.
        start_session();
        check_eq("t2_hold_back", cpu_hold, 1'b1);
        send(5'd10, 5'd0, 5'd1, 5'd0, 5'd0, 16'hFFFF, 26'h0, 1'b0);
        send(5'd16, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0003, 26'h0, 1'b0);
        send(5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b0);
        step();
        check_eq("t2_nwrites", obs_data.size(), 3);
        if (obs_data.size() >= 3) begin
            check_eq("t2_w0", obs_data[0], 32'h2001_FFFF);
            check_eq("t2_w1", obs_data[1], 32'h1022_0003);
            check_eq("t2_w2", obs_data[2], 32'h0800_0010);
            check_eq("t2_a2", obs_addr[2], 2);
        end
        finish_session();

        // Six beats offered into a four-deep session.
        start_session();
        for (int i = 0; i < 6; i++) send(5'd1, 5'(i), 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        step();
        check_eq("t3_nwrites", obs_data.size(), 4);
        for (int i = 0; i < obs_addr.size(); i++) check_eq("t3_addr", obs_addr[i], i);
        check_eq("t3_count", word_count, 4);
        check_eq("t3_full", full, 1'b1);
        check_eq("t3_ready", in_ready, 1'b0);
        finish_session();

        // Field forcing on SLL and ORI.
        start_session();
        send(5'd8, 5'd7, 5'd5, 5'd4, 5'd2, 16'h0, 26'h0, 1'b0);
        send(5'd12, 5'd1, 5'd2, 5'd0, 5'd0, 16'h00FF, 26'h0, 1'b1);
        idle_steps(3);
        check_eq("t4_nwrites", obs_data.size(), 2);
        if (obs_data.size() >= 2) begin
            check_eq("t4_sll", obs_data[0], 32'h0005_2080);
            check_eq("t4_ori", obs_data[1], 32'h3422_00FF);
        end

        // Reset during the write cycle aborts the write.
        start_session();
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
        do_reset();
        idle_steps(2);
        check_eq("t5_nwrites", obs_data.size(), 0);
        check_eq("t5_busy", busy, 1'b0);

        // Illegal op select.
        start_session();
        send(5'd31, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1234, 26'h0, 1'b0);
        step();
`ifdef ENC_ILLEGAL_CHECK_EN
        check_eq("t6_nwrites", obs_data.size(), 0);
        check_eq("t6_err", err, 1'b1);
`else
        check_eq("t6_nwrites", obs_data.size(), 1);
        if (obs_data.size() >= 1) check_eq("t6_nop", obs_data[0], 32'h0);
        check_eq("t6_err", err, 1'b0);
`endif
        finish_session();

        // Random sessions, with stray control pulses and occasional resets.
        for (int s = 0; s < 40; s++) begin
            int unsigned len;
            len = $urandom_range(12, 2);
            if ($urandom_range(3, 0) == 0) begin
                load_done = 1'b1;
                step();
                load_done = 1'b0;
            end
            start_session();
            for (int c = 0; c < int'(len); c++) begin
                in_valid   = ($urandom_range(9, 0) < 7);
                in_op      = ($urandom_range(7, 0) == 0) ? 5'($urandom_range(31, 19))
                                                         : 5'($urandom_range(18, 0));
                in_rs      = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
                in_sa      = 5'($urandom); in_imm = 16'($urandom);
                in_target  = 26'($urandom);
                load_start = ($urandom_range(9, 0) == 0);
                load_done  = (c == int'(len) - 1);
                step();
                if ($urandom_range(49, 0) == 0) do_reset();
            end
            in_valid = 1'b0; load_start = 1'b0; load_done = 1'b0;
            idle_steps($urandom_range(4, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
